load_store_align: RTL and testbench
===================================

# load_store_align

Load/store alignment and memory-sequencing stage between the execute stage and the data memory port. It turns a byte/half/word access at any byte address into one or two word-aligned memory transactions with byte enables. It right-justifies load data into bits [7:0]/[15:0]/[31:0] with the unused upper bits zeroed, and hands the result to the load-data sign/zero extender. Sign/zero extension happens downstream, not here. The block stalls the pipeline while a transaction is in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width; memory addresses are word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  execute stage presents an access
- ReqReady  out  1  block idle and able to accept
- IsStore  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- Addr  in  ADDR_WIDTH  byte address, any alignment
- StoreData  in  32  store operand, right-justified
- LoadData  out  32  right-justified load result; zero above access size
- Done  out  1  one-cycle pulse when the access completes (load or store)
- Stall  out  1  high whenever not idle
- MemReq  out  1  memory request, held until acknowledged
- MemWe  out  1  write enable for the current request
- MemAddr  out  ADDR_WIDTH  word-aligned address, low 2 bits always 0
- MemBe  out  4  byte enables
- MemWData  out  32  lane-positioned write data
- MemAck  in  1  memory accepted the request (write done / read data valid this cycle)
- MemRData  in  32  read data, valid when MemAck is high

## Operation
- States: IDLE, ACC0, ACC1, RESP. ReqReady = (state == IDLE). Stall = !ReqReady.
- Accept on ReqValid && ReqReady. At acceptance, register:
  - op, size, Addr
  - off = Addr[1:0]
  - 8-bit lane mask = base mask << off, where base mask is 0001, 0011 or 1111 per size
  - 64-bit write data = StoreData << (8*off)
  - split = |mask[7:4]
- ACC0: MemReq=1, MemAddr={Addr[hi:2],00}, MemBe=mask[3:0], MemWData=wdata[31:0], MemWe=IsStore.
  - On MemAck, capture MemRData into rbuf[31:0].
  - Next state is ACC1 if split, else RESP.
- ACC1: MemAddr = first word address + 4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0x0). MemBe=mask[7:4], MemWData=wdata[63:32].
  - On MemAck, capture into rbuf[63:32]; go to RESP.
- RESP: Done=1 for exactly one cycle.
  - For loads, LoadData = (rbuf >> 8*off)[31:0], masked to 8/16/32 bits by size. For stores, LoadData = 0.
  - Next state is IDLE.
- MemReq, MemAddr, MemBe, MemWData and MemWe are registered and stable while MemReq is high. MemAck is ignored when MemReq is low.
- Bytes outside the access are never written (MemBe exact).
- LoadData holds its value until the next RESP.

## Timing
- Reset (async, immediate): state IDLE; MemReq, MemWe, MemBe, MemAddr, MemWData, LoadData, Done and Stall all 0; ReqReady=1.
- Reset mid-transaction drops MemReq at once and discards the access; no Done is produced.
- Acceptance at edge k gives MemReq high from cycle k+1.
- With a zero-wait memory (MemAck in the first MemReq cycle), an aligned access gives Done at cycle k+2 and a split access gives Done at k+3. Each wait cycle adds one.
- A new request may be accepted in the cycle after Done (IDLE). Back-to-back throughput is one aligned access per 3 cycles.
- The ACC0 to ACC1 transition drops MemReq for zero cycles: MemReq stays high with the updated address/BE.

## Test plan
- Aligned word load: Addr=0x100, Size=10, memory returns 0xDEADBEEF with zero wait.
  - Expect one MemReq at 0x100, BE=1111; Done at k+2 with LoadData=0xDEADBEEF.
- Byte store at offset 3: Addr=0x203, StoreData=0x000000A5.
  - Expect MemAddr=0x200, BE=1000, MemWData=0xA5000000, MemWe=1.
  - Single transaction; Done at k+2, LoadData=0.
- Split half load: Addr=0x103, Size=01, word 0x100=0x11223344, word 0x104=0x55667788.
  - Expect two requests: 0x100 with BE=1000, then 0x104 with BE=0001.
  - LoadData=0x00008811; Done at k+3.
- Wait states: aligned word load with MemAck delayed 3 cycles.
  - Expect MemReq, MemAddr and MemBe stable throughout and Stall high.
  - Done at k+5; ReqReady low until IDLE.
- Wrap: split word store at Addr=0xFFFFFFFE, StoreData=0xCAFEF00D.
  - Expect 0xFFFFFFFC with BE=1100 and data 0xF00D0000, then 0x00000000 with BE=0011 and data 0x0000CAFE.
- Reset mid-access: assert rst_n=0 during ACC1 wait.
  - Expect MemReq=0 and ReqReady=1 immediately, no Done pulse.
  - A fresh aligned load after release completes normally.

Source files
------------

// File: rtl/load_store_align.sv
// Splits byte/half/word accesses at any alignment into one or two word-aligned memory
// transactions and right-justifies load data; stalls the pipeline while busy.
//   state | meaning
//   IDLE  | ready to accept a request
//   ACC0  | first (lower) word transaction in flight
//   ACC1  | second word transaction of a line-crossing access
//   RESP  | Done pulse, LoadData valid
module load_store_align #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  IsStore,
   input  logic [1:0]            Size,
   input  logic [ADDR_WIDTH-1:0] Addr,
   input  logic [31:0]           StoreData,
   output logic [31:0]           LoadData,
   output logic                  Done,
   output logic                  Stall,
   output logic                  MemReq,
   output logic                  MemWe,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [3:0]            MemBe,
   output logic [31:0]           MemWData,
   input  logic                  MemAck,
   input  logic [31:0]           MemRData
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

   state_t                state_q;
   logic                  is_store_q;
   logic [1:0]            size_q;
   logic [1:0]            off_q;
   logic [7:0]            mask_q;
   logic [63:0]           wdata_q;
   logic                  split_q;
   logic [31:0]           rbuf_lo_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [3:0]            mem_be_q;
   logic [31:0]           mem_wdata_q;
   logic [31:0]           load_data_q;
   logic                  done_q;

   logic [3:0]  base_mask;
   logic [7:0]  mask_d;
   logic [63:0] wdata_d;
   logic [63:0] rbuf_full;
   logic [31:0] rsel;
   logic [31:0] load_d;

   always_comb begin
      case (Size)
         2'b00:   base_mask = 4'b0001;
         2'b01:   base_mask = 4'b0011;
         default: base_mask = 4'b1111;
      endcase
      mask_d  = {4'b0000, base_mask} << Addr[1:0];
      wdata_d = {32'd0, StoreData} << {Addr[1:0], 3'b000};
      // The final beat's read data is folded in directly so LoadData is valid with Done.
      rbuf_full = (state_q == ACC1) ? {MemRData, rbuf_lo_q} : {32'd0, MemRData};
      rsel      = 32'(rbuf_full >> {off_q, 3'b000});
      case (size_q)
         2'b00:   load_d = {24'd0, rsel[7:0]};
         2'b01:   load_d = {16'd0, rsel[15:0]};
         default: load_d = rsel;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         is_store_q  <= 1'b0;
         size_q      <= 2'b00;
         off_q       <= 2'b00;
         mask_q      <= 8'd0;
         wdata_q     <= 64'd0;
         split_q     <= 1'b0;
         rbuf_lo_q   <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         load_data_q <= 32'd0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ReqValid) begin
                  is_store_q  <= IsStore;
                  size_q      <= Size;
                  off_q       <= Addr[1:0];
                  mask_q      <= mask_d;
                  wdata_q     <= wdata_d;
                  split_q     <= |mask_d[7:4];
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= IsStore;
                  mem_addr_q  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_be_q    <= mask_d[3:0];
                  mem_wdata_q <= wdata_d[31:0];
                  state_q     <= ACC0;
               end
            end
            ACC0: begin
               if (MemAck) begin
                  if (split_q) begin
                     rbuf_lo_q   <= MemRData;
                     mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                     mem_be_q    <= mask_q[7:4];
                     mem_wdata_q <= wdata_q[63:32];
                     state_q     <= ACC1;
                  end else begin
                     mem_req_q   <= 1'b0;
                     mem_we_q    <= 1'b0;
                     done_q      <= 1'b1;
                     load_data_q <= is_store_q ? 32'd0 : load_d;
                     state_q     <= RESP;
                  end
               end
            end
            ACC1: begin
               if (MemAck) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  done_q      <= 1'b1;
                  load_data_q <= is_store_q ? 32'd0 : load_d;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ReqReady = (state_q == IDLE);
   assign Stall    = !ReqReady;
   assign MemReq   = mem_req_q;
   assign MemWe    = mem_we_q;
   assign MemAddr  = mem_addr_q;
   assign MemBe    = mem_be_q;
   assign MemWData = mem_wdata_q;
   assign LoadData = load_data_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_load_store_align.sv
// Bench for load_store_align: directed scenarios plus random accesses checked against a
// byte-addressed memory model.
module tb_load_store_align;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ReqValid, ReqReady, IsStore;
   logic [1:0]  Size;
   logic [31:0] Addr, StoreData, LoadData;
   logic        Done, Stall, MemReq, MemWe, MemAck;
   logic [31:0] MemAddr, MemWData, MemRData;
   logic [3:0]  MemBe;

   always #5 clk = ~clk;

   load_store_align #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .IsStore(IsStore), .Size(Size), .Addr(Addr), .StoreData(StoreData),
      .LoadData(LoadData), .Done(Done), .Stall(Stall), .MemReq(MemReq),
      .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  bmem [logic [31:0]];
   logic [31:0] tx_addr [4];
   logic [3:0]  tx_be   [4];
   logic [31:0] tx_wd   [4];
   logic        tx_we   [4];
   int          ntx;
   logic [31:0] last_ld;
   int          last_lat;

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] wa);
      logic [31:0] w;
      for (int l = 0; l < 4; l++) w[8*l +: 8] = byte_at(wa + 32'(l));
      return w;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int l = 0; l < 4; l++) m[8*l +: 8] = be[l] ? 8'hFF : 8'h00;
      return m;
   endfunction

   task automatic set_word(input logic [31:0] wa, input logic [31:0] w);
      for (int l = 0; l < 4; l++) bmem[wa + 32'(l)] = w[8*l +: 8];
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] sd, input int wt);
      int          n, cyc, wcnt, nexp;
      logic        done_seen;
      logic [31:0] ba, exp_ld;
      logic [31:0] ew  [2];
      logic [3:0]  ebe [2];
      logic [31:0] ewd [2];
      n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      exp_ld = 32'd0;
      nexp   = 0;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if (nexp == 0 || ew[nexp-1] != (ba & ~32'd3)) begin
            ew[nexp]  = ba & ~32'd3;
            ebe[nexp] = 4'd0;
            ewd[nexp] = 32'd0;
            nexp++;
         end
         ebe[nexp-1][ba[1:0]]          = 1'b1;
         ewd[nexp-1][8*ba[1:0] +: 8]   = sd[8*i +: 8];
         exp_ld[8*i +: 8]              = byte_at(ba);
      end
      if (st) exp_ld = 32'd0;

      @(negedge clk);
      ReqValid = 1'b1; IsStore = st; Size = sz; Addr = a; StoreData = sd;
      check("req_ready", ReqReady, 1'b1);
      @(posedge clk);
      @(negedge clk);
      ReqValid = 1'b0;
      ntx = 0; wcnt = 0; done_seen = 1'b0; cyc = 1;
      while (cyc < 60 && !done_seen) begin
         MemAck   = 1'b0;
         MemRData = $urandom;
         if (Done) begin
            done_seen = 1'b1;
            last_ld   = LoadData;
            last_lat  = cyc;
         end else begin
            check("busy_flags", {ReqReady, Stall}, 2'b01);
            if (MemReq && ntx < 4) begin
               if (wcnt == 0) begin
                  tx_addr[ntx] = MemAddr; tx_be[ntx] = MemBe;
                  tx_wd[ntx]   = MemWData; tx_we[ntx] = MemWe;
               end else begin
                  check("hold_addr", MemAddr, tx_addr[ntx]);
                  check("hold_be", MemBe, tx_be[ntx]);
                  check("hold_wd", MemWData, tx_wd[ntx]);
               end
               if (wcnt == wt) begin
                  MemAck   = 1'b1;
                  MemRData = word_at(MemAddr);
                  if (MemWe)
                     for (int l = 0; l < 4; l++)
                        if (MemBe[l]) bmem[MemAddr + 32'(l)] = MemWData[8*l +: 8];
                  ntx++;
                  wcnt = 0;
               end else begin
                  wcnt++;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      MemAck = 1'b0;
      check("done_seen", done_seen, 1'b1);
      if (done_seen) begin
         check("latency", 64'(last_lat), 64'(1 + nexp * (wt + 1)));
         check("load_data", last_ld, exp_ld);
         check("num_tx", 64'(ntx), 64'(nexp));
         for (int j = 0; j < nexp && j < ntx; j++) begin
            check("tx_addr", tx_addr[j], ew[j]);
            check("tx_be", tx_be[j], ebe[j]);
            check("tx_we", tx_we[j], st);
            if (st) check("tx_wdata", tx_wd[j] & lane_mask(ebe[j]), ewd[j]);
         end
         @(negedge clk);
         check("after_done", {Done, ReqReady, Stall, MemReq}, 4'b0100);
         check("ld_hold", LoadData, last_ld);
      end
   endtask

   initial begin
      rst_n = 1'b0; ReqValid = 1'b0; IsStore = 1'b0; Size = 2'b00; Addr = 32'd0;
      StoreData = 32'd0; MemAck = 1'b0; MemRData = 32'd0;
      #12;
      check("rst_outputs", {MemReq, MemWe, MemBe, Done, Stall, ReqReady}, 9'b000000001);
      check("rst_addr", MemAddr, 32'd0);
      check("rst_wdata", MemWData, 32'd0);
      check("rst_ld", LoadData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      set_word(32'h100, 32'hDEADBEEF);
      run_access(1'b0, 2'b10, 32'h100, 32'd0, 0);
      check("t1_ld", last_ld, 32'hDEADBEEF);

      run_access(1'b1, 2'b00, 32'h203, 32'h000000A5, 0);
      check("t2_wdata", tx_wd[0], 32'hA5000000);

      set_word(32'h100, 32'h11223344);
      set_word(32'h104, 32'h55667788);
      run_access(1'b0, 2'b01, 32'h103, 32'd0, 0);
      check("t3_ld", last_ld, 32'h00008811);

      run_access(1'b0, 2'b10, 32'h100, 32'd0, 3);
      check("t4_lat", 64'(last_lat), 64'd5);

      run_access(1'b1, 2'b10, 32'hFFFFFFFE, 32'hCAFEF00D, 0);
      check("t5_wd0", tx_wd[0], 32'hF00D0000);
      check("t5_addr1", tx_addr[1], 32'h00000000);
      check("t5_wd1", tx_wd[1], 32'h0000CAFE);
      run_access(1'b0, 2'b11, 32'hFFFFFFFE, 32'd0, 1);
      check("t5_readback", last_ld, 32'hCAFEF00D);

      @(negedge clk);
      ReqValid = 1'b1; IsStore = 1'b0; Size = 2'b10; Addr = 32'h301;
      @(posedge clk);
      @(negedge clk);
      ReqValid = 1'b0;
      check("t6_req0", MemReq, 1'b1);
      MemAck = 1'b1; MemRData = word_at(MemAddr);
      @(negedge clk);
      MemAck = 1'b0;
      check("t6_addr1", {MemReq, MemAddr}, {1'b1, 32'h304});
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("t6_rst", {MemReq, ReqReady, Stall, Done}, 4'b0100);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_done", {Done, ReqReady}, 2'b01);
      end
      set_word(32'h400, 32'h0BADCAFE);
      run_access(1'b0, 2'b10, 32'h400, 32'd0, 0);
      check("t6_fresh", last_ld, 32'h0BADCAFE);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] base, ra;
         case ($urandom_range(0, 2))
            0:       base = 32'h100;
            1:       base = 32'h1000;
            default: base = 32'hFFFFFFF4;
         endcase
         ra = base + 32'($urandom_range(0, 11));
         run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                    int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
